// File: rtl/video_timing_detector.sv
// Receive-side video timing measurement: recovers line/frame totals, active sizes and
// sync polarities from HS/VS/DE, and flags lock once several frames agree.
module video_timing_detector #(
  parameter int H_W           = 12,
  parameter int V_W           = 12,
  parameter int STABLE_FRAMES = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           vid_hs,
  input  logic           vid_vs,
  input  logic           vid_de,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_active,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_active,
  output logic           hs_pol,
  output logic           vs_pol,
  output logic           locked,
  output logic           frame_done,
  output logic           overflow
);

  localparam int             SW         = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0]  STABLE_MAX = SW'(STABLE_FRAMES);
  localparam logic [H_W-1:0] H_MAX      = '1;
  localparam logic [V_W-1:0] V_MAX      = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t state, state_next;

  logic s1_hs, s1_vs, s1_de;
  logic s2_hs, s2_vs, s2_de;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s2_hs <= 1'b0;
      s2_vs <= 1'b0;
      s2_de <= 1'b0;
    end else begin
      s1_hs <= vid_hs;
      s1_vs <= vid_vs;
      s1_de <= vid_de;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_de <= s1_de;
    end
  end

  // Leading edges are judged against the stored polarity: entry into the sync level.
  logic hs_lead, vs_lead, de_rise, pol_change;
  assign hs_lead    = (s1_hs == hs_pol) && (s2_hs != hs_pol);
  assign vs_lead    = (s1_vs == vs_pol) && (s2_vs != vs_pol);
  assign de_rise    = s1_de && !s2_de;
  assign pol_change = de_rise && ((~s1_hs != hs_pol) || (~s1_vs != vs_pol));

  logic [H_W-1:0] hcnt, decnt, line_total, line_active;
  logic [V_W-1:0] vcnt, vact;
  logic           ovf_acc;
  logic           sat_now, close_active;

  assign sat_now      = (hcnt == H_MAX) || (decnt == H_MAX) || (vcnt == V_MAX) || (vact == V_MAX);
  assign close_active = hs_lead && (decnt != '0);

  // Line-level counters run continuously; frame-level ones restart at each VS leading edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      decnt       <= '0;
      line_total  <= '0;
      line_active <= '0;
      vcnt        <= '0;
      vact        <= '0;
      ovf_acc     <= 1'b0;
    end else begin
      if (hs_lead) begin
        hcnt       <= H_W'(1);
        line_total <= hcnt;
      end else if (hcnt != H_MAX) begin
        hcnt <= hcnt + H_W'(1);
      end

      if (hs_lead) begin
        decnt <= s1_de ? H_W'(1) : '0;
      end else if (s1_de && (decnt != H_MAX)) begin
        decnt <= decnt + H_W'(1);
      end

      if (close_active) begin
        line_active <= decnt;
      end

      if (vs_lead) begin
        // A coincident HS edge opens line 1 of the new frame.
        vcnt    <= hs_lead ? V_W'(1) : '0;
        vact    <= '0;
        ovf_acc <= 1'b0;
      end else begin
        if (hs_lead && (vcnt != V_MAX)) begin
          vcnt <= vcnt + V_W'(1);
        end
        if (close_active && (vact != V_MAX)) begin
          vact <= vact + V_W'(1);
        end
        if (sat_now) begin
          ovf_acc <= 1'b1;
        end
      end
    end
  end

  logic [H_W-1:0] snap_h_total, snap_h_active;
  logic [V_W-1:0] snap_v_total, snap_v_active;
  logic           snap_ovf;

  // Snapshot at the VS edge; an HS edge in the same cycle closes the last line of the old frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_h_total  <= '0;
      snap_h_active <= '0;
      snap_v_total  <= '0;
      snap_v_active <= '0;
      snap_ovf      <= 1'b0;
    end else if (vs_lead) begin
      snap_h_total  <= hs_lead ? hcnt : line_total;
      snap_h_active <= close_active ? decnt : line_active;
      snap_v_total  <= vcnt;
      snap_v_active <= (close_active && (vact != V_MAX)) ? vact + V_W'(1) : vact;
      snap_ovf      <= ovf_acc || sat_now;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  logic do_report, lost_vs;

  always_comb begin
    state_next = state;
    do_report  = 1'b0;
    lost_vs    = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_lead) state_next = MEASURE;
      end
      MEASURE: begin
        if (vs_lead) begin
          state_next = COMPARE;
        end else if (vcnt == V_MAX) begin
          state_next = SEARCH;
          lost_vs    = 1'b1;
        end
      end
      COMPARE: begin
        state_next = MEASURE;
        do_report  = 1'b1;
      end
      default: state_next = SEARCH;
    endcase
    if (pol_change) begin
      state_next = SEARCH;
      do_report  = 1'b0;
      lost_vs    = 1'b0;
    end
  end

  logic [SW-1:0] stable;
  logic          same_geom;

  assign same_geom = (snap_h_total == h_total) && (snap_h_active == h_active) &&
                     (snap_v_total == v_total) && (snap_v_active == v_active);
  assign locked    = (stable == STABLE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      hs_pol     <= 1'b0;
      vs_pol     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      stable     <= '0;
    end else begin
      frame_done <= do_report;
      if (do_report) begin
        h_total  <= snap_h_total;
        h_active <= snap_h_active;
        v_total  <= snap_v_total;
        v_active <= snap_v_active;
        overflow <= snap_ovf;
        if (snap_ovf) begin
          stable <= '0;
        end else if (same_geom) begin
          stable <= (stable == STABLE_MAX) ? STABLE_MAX : stable + SW'(1);
        end else begin
          stable <= SW'(1);
        end
      end
      if (lost_vs) begin
        overflow <= 1'b1;
        stable   <= '0;
      end
      if (pol_change) begin
        hs_pol <= ~s1_hs;
        vs_pol <= ~s1_vs;
        stable <= '0;
      end
    end
  end

endmodule

// File: doc/video_timing_detector.md
# video_timing_detector

Measures the timing of an incoming parallel video stream (HS/VS/DE on its own pixel clock) and reports horizontal and vertical totals, active sizes and sync polarities, with a lock flag once the geometry is stable. It is the receive-side counterpart of the LCD timing generator that drives the MTL2 panel. It sits on the HDMI-RX or MIPI pixel path ahead of capture logic, and its results are exported to the Qsys system through a PIO conduit.

## Interface
- H_W, 12: width of horizontal counters and outputs.
- V_W, 12: width of vertical counters and outputs.
- STABLE_FRAMES, 3: number of consecutive identical frames required to assert `locked` (minimum 2).

Ports:
- `clk`  in  1  pixel clock; all logic is in this single domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vid_hs`  in  1  horizontal sync, synchronous to `clk`, either polarity.
- `vid_vs`  in  1  vertical sync, synchronous to `clk`, either polarity.
- `vid_de`  in  1  data enable, active high.
- `h_total`  out  H_W  clocks per line.
- `h_active`  out  H_W  DE-high clocks in a line.
- `v_total`  out  V_W  lines per frame.
- `v_active`  out  V_W  lines containing at least one DE-high clock.
- `hs_pol`  out  1  1 = active-high HS.
- `vs_pol`  out  1  1 = active-low VS is 0, active-high VS is 1.
- `locked`  out  1  geometry stable.
- `frame_done`  out  1  one-cycle pulse when the frame results update.
- `overflow`  out  1  sticky until the next good frame; a counter saturated in the last frame.

## Operation
- Inputs are registered once (stage s1), then delayed again (s2). An edge is s1 != s2.
- Polarity is detected on every DE rising edge: `hs_pol` = ~s1_hs and `vs_pol` = ~s1_vs, because active video always lies outside sync. If either sampled polarity differs from the stored value:
  - the stored value updates;
  - the FSM goes to SEARCH;
  - `locked` clears.
- A leading edge is the transition into the sync level given by the stored polarity.
- FSM states:
  - SEARCH: wait for a VS leading edge, then clear the accumulators and go to MEASURE.
  - MEASURE: accumulate counts. At the next VS leading edge, go to COMPARE.
  - COMPARE (1 cycle): latch the results, pulse `frame_done`, update the stability count, clear the accumulators, and return to MEASURE.
- Horizontal counting:
  - `hcnt` counts clocks since the last HS leading edge.
  - At each HS leading edge, `hcnt` is captured as the line total (the count is inclusive of the edge cycle).
  - `decnt` counts DE-high clocks in the current line. At each HS edge, if `decnt` != 0, it is captured as the line's active count, and the line counter for active lines increments.
- Vertical counting:
  - The line count increments on each HS leading edge.
  - A coincident HS and VS leading edge counts as line 1 of the new frame.
- Frame results are taken from the values captured at the last HS edge before the VS edge.
- Stability:
  - If the new {h_total, h_active, v_total, v_active} equals the previous set and no counter saturated, the stable count increments, saturating at STABLE_FRAMES.
  - Otherwise the stable count becomes 1 and `locked` drops.
  - `locked` = (stable count == STABLE_FRAMES).
- Saturation: any counter reaching all-ones holds its value and sets a frame-overflow flag. An overflowing frame:
  - is reported with its saturated values;
  - sets `overflow`;
  - sets the stable count to 0;
  - clears `locked`.
- Missing VS: when the line counter saturates, the FSM goes to SEARCH, sets `overflow` and clears `locked`. There is no `frame_done` pulse.

## Timing
- Reset values: all outputs 0, including `hs_pol` and `vs_pol` (active-low default). The FSM starts in SEARCH.
- Latency: a VS leading edge first present on `vid_vs` at clock edge k gives updated outputs and `frame_done`=1 during the cycle after edge k+2. Outputs then hold until the next COMPARE.
- A polarity change takes effect 2 cycles after the DE rising edge is sampled.
- Reset asserted mid-frame clears everything immediately. Measurement restarts from SEARCH, so the first results come at the second VS leading edge after reset is released.
- No back-pressure and no handshake: `frame_done` is informational only.

## Test plan
- Frame with h_total=20, DE=12 per line, 6 active lines, v_total=10, active-low syncs:
  - frame_done pulses at every VS edge after the first;
  - outputs read 20/12/10/6 and pols 0/0;
  - `locked`=1 after the 3rd report.
- Same stream with active-high syncs:
  - hs_pol=vs_pol=1 after the first DE;
  - identical counts;
  - `locked` follows after 3 reports.
- Locked stream, then one frame with h_total=21 → `locked` drops at that report, and re-asserts 3 reports after returning to 20.
- Stream with VS removed: line counter saturates at 4095 → `overflow`=1, `locked`=0, no frame_done. After VS is restored, the first good report clears `overflow`.
- Syncs flip polarity mid-frame → `locked` drops within 2 cycles of the next DE rise, and the next valid report uses the new polarity.
- reset_n pulsed low mid-frame → all outputs 0 asynchronously, and the first frame_done occurs at the second VS edge after release.
